// File: rtl/input_stage_pkg.sv
// Shared constants and the bit-serial CRC-16-CCITT step used by the input stage.
//   WORD_W   : payload word width
//   NUM_CH   : number of serial lanes
//   CRC_POLY : CRC-16-CCITT generator (non-reflected)
//   CRC_INIT : CRC register seed at frame start
package input_stage_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned NUM_CH   = 8;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Advance the CRC register by one received bit, MSB-first, no reflection.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/input_stage_rx_lane.sv
// One serial receive lane: shift register, bit counter, running CRC,
// pending word register and a single-entry hold buffer toward the arbiter.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   din, vld          : serial bit and bit-valid (one high run = one frame)
//   grant             : arbiter takes the hold buffer this cycle
//   hold_vld/hold_data: hold buffer contents offered to the arbiter
//   frame_done, crc_err, frm_err, ovf : one-cycle status pulses
module rx_lane
    import input_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              vld,
    input  logic              grant,
    output logic              hold_vld,
    output logic [WORD_W-1:0] hold_data,
    output logic              frame_done,
    output logic              crc_err,
    output logic              frm_err,
    output logic              ovf
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       crc_q, crc_d;
    logic              in_frame_q, in_frame_d;
    logic              got_word_q, got_word_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              frame_done_q, frame_done_d;
    logic              crc_err_q, crc_err_d;
    logic              frm_err_q, frm_err_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] word_c;

    // Next-state: bit capture, word completion, pending->hold move, frame end.
    always_comb begin : lane_next
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        in_frame_d   = in_frame_q;
        got_word_d   = got_word_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        frame_done_d = 1'b0;
        crc_err_d    = 1'b0;
        frm_err_d    = 1'b0;
        ovf_d        = 1'b0;
        word_c       = {shift_q[WORD_W-2:0], din};

        if (grant) begin
            hold_vld_d = 1'b0;
        end

        if (vld) begin
            in_frame_d = 1'b1;
            shift_d    = word_c;
            cnt_d      = cnt_q + CNT_W'(1);
            crc_d      = crc16_next(crc_q, din);
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
                got_word_d = 1'b1;
                pend_d     = word_c;
                pend_vld_d = 1'b1;
                // Older pending word is now known to be payload, not CRC.
                if (pend_vld_q) begin
                    if (hold_vld_q && !grant) begin
                        ovf_d = 1'b1;
                    end else begin
                        hold_d     = pend_q;
                        hold_vld_d = 1'b1;
                    end
                end
            end
        end else if (in_frame_q) begin
            // Frame end: pending word is the CRC and is discarded.
            in_frame_d   = 1'b0;
            frame_done_d = 1'b1;
            frm_err_d    = (cnt_q != '0) || !got_word_q;
            crc_err_d    = !frm_err_d && (crc_q != 16'h0000);
            shift_d      = '0;
            cnt_d        = '0;
            crc_d        = CRC_INIT;
            got_word_d   = 1'b0;
            pend_vld_d   = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin : lane_regs
        if (rst) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            crc_q        <= CRC_INIT;
            in_frame_q   <= 1'b0;
            got_word_q   <= 1'b0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            crc_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            in_frame_q   <= in_frame_d;
            got_word_q   <= got_word_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            frame_done_q <= frame_done_d;
            crc_err_q    <= crc_err_d;
            frm_err_q    <= frm_err_d;
            ovf_q        <= ovf_d;
        end
    end

    assign hold_vld   = hold_vld_q;
    assign hold_data  = hold_q;
    assign frame_done = frame_done_q;
    assign crc_err    = crc_err_q;
    assign frm_err    = frm_err_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/input_stage.sv
// Eight-lane serial input stage: per-lane deserialisers feed a round-robin
// arbiter and a single registered valid/ready output word.
// Ports:
//   clk_in16x, rst                : clock, synchronous active-high reset
//   data_in_chN, data_vld_chN     : serial lane bit and bit-valid, N = 1..8
//   m_valid, m_ready, m_data, m_ch: output word handshake, payload, source lane
//   frame_done, crc_err, frm_err, ovf : per-lane one-cycle status pulses
module input_stage #(
    parameter int unsigned NUM_CH = input_stage_pkg::NUM_CH,
    parameter int unsigned WORD_W = input_stage_pkg::WORD_W
) (
    input  logic                      clk_in16x,
    input  logic                      rst,
    input  logic                      data_in_ch1,
    input  logic                      data_in_ch2,
    input  logic                      data_in_ch3,
    input  logic                      data_in_ch4,
    input  logic                      data_in_ch5,
    input  logic                      data_in_ch6,
    input  logic                      data_in_ch7,
    input  logic                      data_in_ch8,
    input  logic                      data_vld_ch1,
    input  logic                      data_vld_ch2,
    input  logic                      data_vld_ch3,
    input  logic                      data_vld_ch4,
    input  logic                      data_vld_ch5,
    input  logic                      data_vld_ch6,
    input  logic                      data_vld_ch7,
    input  logic                      data_vld_ch8,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WORD_W-1:0]         m_data,
    output logic [$clog2(NUM_CH)-1:0] m_ch,
    output logic [NUM_CH-1:0]         frame_done,
    output logic [NUM_CH-1:0]         crc_err,
    output logic [NUM_CH-1:0]         frm_err,
    output logic [NUM_CH-1:0]         ovf
);

    import input_stage_pkg::*;

    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [7:0]        din_all;
    logic [7:0]        vld_all;
    logic [NUM_CH-1:0] hold_vld;
    logic [NUM_CH-1:0] grant_c;
    logic [WORD_W-1:0] hold_data [NUM_CH];

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   gnt_idx_c;
    logic [CH_W:0]     sum_c;
    logic [CH_W-1:0]   idx_c;
    logic              gnt_vld_c;
    logic              out_free_c;

    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic [CH_W-1:0]   m_ch_q, m_ch_d;

    assign din_all = {data_in_ch8, data_in_ch7, data_in_ch6, data_in_ch5,
                      data_in_ch4, data_in_ch3, data_in_ch2, data_in_ch1};
    assign vld_all = {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
                      data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        rx_lane u_lane (
            .clk        (clk_in16x),
            .rst        (rst),
            .din        (din_all[g]),
            .vld        (vld_all[g]),
            .grant      (grant_c[g]),
            .hold_vld   (hold_vld[g]),
            .hold_data  (hold_data[g]),
            .frame_done (frame_done[g]),
            .crc_err    (crc_err[g]),
            .frm_err    (frm_err[g]),
            .ovf        (ovf[g])
        );
    end

    // Round-robin pick: first full hold buffer at or after ptr_q.
    always_comb begin : arb
        gnt_vld_c  = 1'b0;
        gnt_idx_c  = ptr_q;
        grant_c    = '0;
        sum_c      = '0;
        idx_c      = '0;
        out_free_c = !m_valid_q || m_ready;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum_c = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (sum_c >= (CH_W+1)'(NUM_CH)) begin
                sum_c = sum_c - (CH_W+1)'(NUM_CH);
            end
            idx_c = sum_c[CH_W-1:0];
            if (out_free_c && !gnt_vld_c && hold_vld[idx_c]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = idx_c;
            end
        end
        if (gnt_vld_c) begin
            grant_c[gnt_idx_c] = 1'b1;
        end
    end

    // Output register load/release and arbiter pointer advance.
    always_comb begin : out_next
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        ptr_d     = ptr_q;
        if (gnt_vld_c) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_data[gnt_idx_c];
            m_ch_d    = gnt_idx_c;
            ptr_d     = (gnt_idx_c == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output and arbiter registers.
    always_ff @(posedge clk_in16x) begin : out_regs
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            ptr_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            ptr_q     <= ptr_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;

endmodule

// File: tb/tb_input_stage.sv
// Self-checking bench for input_stage: directed frames plus random
// multi-lane traffic checked against a word/frame-level reference model.
module tb_input_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic [7:0]  vld = '0;
    logic        m_ready = 1'b1;
    logic        m_valid;
    logic [15:0] m_data;
    logic [2:0]  m_ch;
    logic [7:0]  frame_done, crc_err, frm_err, ovf;

    int vectors = 0;
    int miscompares = 0;

    // Per-lane stimulus stream: {vld, bit}
    logic [1:0]  lane_q    [8][$];
    logic [15:0] out_got   [8][$];
    logic [1:0]  fd_got    [8][$];
    logic [15:0] exp_words [8][$];
    logic [1:0]  exp_fd    [8][$];
    logic [2:0]  ch_order  [$];
    int          ovf_cnt   [8];
    int          exp_ovf   [8];
    int          stray_cnt = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [2:0]  prev_ch;

    input_stage dut (
        .clk_in16x    (clk),
        .rst          (rst),
        .data_in_ch1  (din[0]), .data_in_ch2 (din[1]), .data_in_ch3 (din[2]), .data_in_ch4 (din[3]),
        .data_in_ch5  (din[4]), .data_in_ch6 (din[5]), .data_in_ch7 (din[6]), .data_in_ch8 (din[7]),
        .data_vld_ch1 (vld[0]), .data_vld_ch2 (vld[1]), .data_vld_ch3 (vld[2]), .data_vld_ch4 (vld[3]),
        .data_vld_ch5 (vld[4]), .data_vld_ch6 (vld[5]), .data_vld_ch7 (vld[6]), .data_vld_ch8 (vld[7]),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_ch         (m_ch),
        .frame_done   (frame_done),
        .crc_err      (crc_err),
        .frm_err      (frm_err),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Word-at-a-time CRC-16-CCITT (init FFFF, poly 1021, MSB first).
    function automatic logic [15:0] crc_of(input logic [15:0] ws[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < ws.size(); k++) begin
            c = c ^ ws[k];
            for (int b = 0; b < 16; b++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    // Observer: records delivered words, frame status and overflow pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_ch", 32'(m_ch), 32'(prev_ch));
            end
            if (m_valid && m_ready) begin
                out_got[m_ch].push_back(m_data);
                ch_order.push_back(m_ch);
            end
            for (int i = 0; i < 8; i++) begin
                if (frame_done[i]) fd_got[i].push_back({crc_err[i], frm_err[i]});
                else if (crc_err[i] || frm_err[i]) stray_cnt++;
                if (ovf[i]) ovf_cnt[i]++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_ch    = m_ch;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (lane_q[i].size() > 0) begin
                logic [1:0] e;
                e = lane_q[i].pop_front();
                vld[i] = e[1];
                din[i] = e[0];
            end else begin
                vld[i] = 1'b0;
                din[i] = 1'b0;
            end
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < 8; i++) if (lane_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int limit);
        int t;
        t = 0;
        while (busy() && t < limit) begin
            step();
            t++;
        end
        check("drain_timeout", 32'(busy()), 32'd0);
        repeat (40) step();
    endtask

    task automatic push_gap(input int ln, input int n);
        for (int k = 0; k < n; k++) lane_q[ln].push_back(2'b00);
    endtask

    task automatic push_words(input int ln, input logic [15:0] ws[$]);
        for (int k = 0; k < ws.size(); k++) begin
            logic [15:0] w;
            w = ws[k];
            for (int b = 15; b >= 0; b--) lane_q[ln].push_back({1'b1, w[b]});
        end
    endtask

    // Well-formed frame: payload words then CRC (optionally with one bit flipped).
    task automatic good_frame(input int ln, input int n, input bit corrupt);
        logic [15:0] ws[$];
        logic [15:0] c;
        for (int k = 0; k < n; k++) begin
            ws.push_back(16'($urandom));
            exp_words[ln].push_back(ws[k]);
        end
        c = crc_of(ws);
        if (corrupt) c = c ^ (16'd1 << $urandom_range(15, 0));
        ws.push_back(c);
        push_words(ln, ws);
        push_gap(ln, 1);
        exp_fd[ln].push_back({corrupt, 1'b0});
    endtask

    // Frame of len bits, not a whole number of words: all completed words but the last are delivered.
    task automatic bad_frame(input int ln, input int len);
        logic [15:0] ws[$];
        logic [15:0] tail;
        int nf;
        nf = len / 16;
        for (int k = 0; k < nf; k++) begin
            ws.push_back(16'($urandom));
            if (k < nf - 1) exp_words[ln].push_back(ws[k]);
        end
        push_words(ln, ws);
        tail = 16'($urandom);
        for (int b = 15; b > 15 - (len % 16); b--) lane_q[ln].push_back({1'b1, tail[b]});
        push_gap(ln, 1);
        exp_fd[ln].push_back(2'b01);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 8; i++) begin
            lane_q[i].delete();
            out_got[i].delete();
            fd_got[i].delete();
            exp_words[i].delete();
            exp_fd[i].delete();
            ovf_cnt[i] = 0;
            exp_ovf[i] = 0;
        end
        ch_order.delete();
        stray_cnt = 0;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            int n;
            check($sformatf("%s_l%0d_nwords", tag, i), 32'(out_got[i].size()), 32'(exp_words[i].size()));
            n = (out_got[i].size() < exp_words[i].size()) ? out_got[i].size() : exp_words[i].size();
            for (int k = 0; k < n; k++)
                check($sformatf("%s_l%0d_word%0d", tag, i, k), 32'(out_got[i][k]), 32'(exp_words[i][k]));
            check($sformatf("%s_l%0d_nframes", tag, i), 32'(fd_got[i].size()), 32'(exp_fd[i].size()));
            n = (fd_got[i].size() < exp_fd[i].size()) ? fd_got[i].size() : exp_fd[i].size();
            for (int k = 0; k < n; k++)
                check($sformatf("%s_l%0d_crc_frm%0d", tag, i, k), 32'(fd_got[i][k]), 32'(exp_fd[i][k]));
            check($sformatf("%s_l%0d_ovf", tag, i), 32'(ovf_cnt[i]), 32'(exp_ovf[i]));
        end
        check({tag, "_stray_err"}, 32'(stray_cnt), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] ws[$];
        int nfr, kind, len;

        // Reset state
        do_reset();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_ch", 32'(m_ch), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_crc_err", 32'(crc_err), 32'd0);
        check("rst_frm_err", 32'(frm_err), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // ch1 0x0000 + good CRC 0x1D0F
        clear_all();
        ws = {16'h0000, 16'h1D0F};
        push_words(0, ws);
        push_gap(0, 1);
        exp_words[0].push_back(16'h0000);
        exp_fd[0].push_back(2'b00);
        drain(200);
        compare_all("good_zero");
        check("good_zero_ch", 32'(ch_order.size() == 1 ? ch_order[0] : 3'd7), 32'd0);

        // ch1 0x0000 + bad CRC 0x1D0E
        clear_all();
        ws = {16'h0000, 16'h1D0E};
        push_words(0, ws);
        push_gap(0, 1);
        exp_words[0].push_back(16'h0000);
        exp_fd[0].push_back(2'b10);
        drain(200);
        compare_all("bad_crc");

        // ch3 23-bit frame
        clear_all();
        bad_frame(2, 23);
        drain(200);
        compare_all("len23");

        // All lanes, same 4-word frame, from a fresh arbiter pointer
        do_reset();
        clear_all();
        ws.delete();
        for (int k = 0; k < 4; k++) ws.push_back(16'($urandom));
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) exp_words[i].push_back(ws[k]);
            exp_fd[i].push_back(2'b00);
        end
        ws.push_back(crc_of(ws));
        for (int i = 0; i < 8; i++) begin
            push_words(i, ws);
            push_gap(i, 1);
        end
        drain(400);
        compare_all("all_lanes");
        check("all_lanes_count", 32'(ch_order.size()), 32'd32);
        for (int k = 0; k < ch_order.size() && k < 32; k++)
            check($sformatf("rr_order%0d", k), 32'(ch_order[k]), 32'(k % 8));

        // Backpressure: 0x1111 held, 0x2222 in hold, 0x3333 dropped
        clear_all();
        m_ready = 1'b0;
        ws = {16'h1111, 16'h2222, 16'h3333};
        ws.push_back(crc_of(ws));
        push_words(0, ws);
        push_gap(0, 1);
        drain(400);
        check("bp_ovf_once", 32'(ovf_cnt[0]), 32'd1);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data", 32'(m_data), 32'h1111);
        m_ready = 1'b1;
        repeat (10) step();
        exp_words[0].push_back(16'h1111);
        exp_words[0].push_back(16'h2222);
        exp_fd[0].push_back(2'b00);
        exp_ovf[0] = 1;
        compare_all("backpressure");

        // Reset at bit 9 of ch5's second word abandons the frame
        clear_all();
        ws.delete();
        for (int k = 0; k < 2; k++) ws.push_back(16'($urandom));
        ws.push_back(crc_of(ws));
        push_words(4, ws);
        repeat (25) step();
        lane_q[4].delete();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();
        compare_all("mid_rst");
        clear_all();
        good_frame(4, 3, 1'b0);
        drain(400);
        compare_all("post_rst");

        // Random multi-lane traffic
        for (int r = 0; r < 6; r++) begin
            clear_all();
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(3, 0) != 0) begin
                    push_gap(i, int'($urandom_range(20, 0)));
                    nfr = int'($urandom_range(2, 1));
                    for (int f = 0; f < nfr; f++) begin
                        kind = int'($urandom_range(9, 0));
                        if (kind < 6) good_frame(i, int'($urandom_range(3, 0)), 1'b0);
                        else if (kind < 8) good_frame(i, int'($urandom_range(3, 0)), 1'b1);
                        else begin
                            do len = int'($urandom_range(79, 1)); while (len % 16 == 0);
                            bad_frame(i, len);
                        end
                        push_gap(i, int'($urandom_range(3, 0)));
                    end
                end
            end
            drain(2000);
            compare_all($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_stage.md
INPUT_STAGE -- requirements
Module: input_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port order is clock and reset first.
REQ-002 clk_in16x  input  1  16x bit clock; all logic rises on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 data_in_ch1..data_in_ch8  input  1 each  serial lane data, MSB first.
REQ-005 data_vld_ch1..data_vld_ch8  input  1 each  lane bit-valid; one continuous high run = one frame.
REQ-006 m_valid  output  1  parallel word available.
REQ-007 m_ready  input  1  downstream accepts word.
REQ-008 m_data  output  16  received payload word.
REQ-009 m_ch  output  3  source lane (0 = ch1 .. 7 = ch8).
REQ-010 frame_done  output  8  one-cycle pulse per lane at frame end.
REQ-011 crc_err  output  8  one-cycle pulse with frame_done when CRC residue nonzero.
REQ-012 frm_err  output  8  one-cycle pulse with frame_done when frame bit count is not a nonzero multiple of 16.
REQ-013 ovf  output  8  one-cycle pulse when a payload word is dropped.
REQ-014 Parameter NUM_CH, default 8, lane count; parameter WORD_W, default 16, word width.

Function
REQ-015 Frame format: N>=0 payload words then one 16-bit CRC word, data_vld continuously high, MSB first.
REQ-016 CRC SHALL be CRC-16-CCITT, poly 0x1021, init 0xFFFF, non-reflected, no final XOR, computed over all frame bits including the appended CRC.
REQ-017 A frame is CRC-good iff the CRC register equals 0x0000 after the last bit.
REQ-018 Each lane SHALL sample data_in on every posedge with data_vld high, shift into a 16-bit register and update a 4-bit bit counter (wraps 15->0).
REQ-019 On the 16th bit, the completed word SHALL enter the lane pending register; any earlier pending word moves to the lane hold buffer in the same cycle.
REQ-020 At frame end (data_vld sampled low after high), the pending word is the CRC and SHALL be discarded; frame_done pulses one cycle later; CRC and counters reinitialise.
REQ-021 Bit counter nonzero at frame end, or zero completed words: frm_err SHALL pulse; crc_err SHALL not pulse for that frame.
REQ-022 Hold buffer full and not granted when a pending word moves in: the incoming word SHALL be dropped, ovf pulses, and the held word is kept. If the held word is granted in the same cycle, the move SHALL succeed without ovf.
REQ-023 Arbiter: round-robin over lanes with full hold buffers, starting after the last granted lane; a grant is allowed when the output register is empty or m_valid&&m_ready.
REQ-024 The output register SHALL load one cycle after the grant. m_data and m_ch SHALL stay stable while m_valid&&!m_ready.
REQ-025 Latency: hold buffer full to m_valid high SHALL be 1 cycle when the output is free. Throughput SHALL be 1 word/cycle with m_ready held high.
REQ-026 A data_vld low pulse of any length SHALL end the frame; the next high cycle starts a new frame.

Reset
REQ-027 While rst is high, at the next edge: m_valid=0, m_data=0, m_ch=0, frame_done/crc_err/frm_err/ovf=0.
REQ-028 Reset SHALL also clear all shift, pending and hold registers and the bit counters, set the CRC registers to 0xFFFF, and point the arbiter at lane 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse; a frame whose data_vld is already high when rst releases starts from the first sampled bit.

Structure
REQ-030 Shared package input_stage_pkg SHALL hold CRC_POLY, CRC_INIT, WORD_W, NUM_CH and the crc16 next-bit function.
REQ-031 A single sub-module rx_lane (shift, CRC, pending and hold registers for one lane) SHALL be instantiated NUM_CH times. The top level contains the arbiter and output register.

Verification
REQ-032 ch1 frame 0x0000,0x1D0F with m_ready=1 -> one word m_data=0x0000, m_ch=0; frame_done[0]=1; crc_err[0]=0.
REQ-033 ch1 frame 0x0000,0x1D0E -> word 0x0000 delivered; frame_done[0]=1 and crc_err[0]=1 together.
REQ-034 ch3 frame of 23 bits -> frm_err[2]=1 with frame_done[2]; no CRC word appears on m_data.
REQ-035 All 8 lanes send the same 4-word frame simultaneously, m_ready=1 -> 32 words out in round-robin m_ch order 0..7 per word index; no ovf.
REQ-036 m_ready=0 while ch1 sends 0x1111,0x2222,0x3333,CRC -> 0x1111 held on m_data, 0x2222 in hold, 0x3333 dropped; ovf[0]=1 once.
REQ-037 rst pulsed at bit 9 of a ch5 word -> no frame_done[4]; the following good frame on ch5 is received with crc_err[4]=0.
